// File: rtl/mnd_sequencer.sv
// mnd_sequencer: multi-cycle multiply/divide controller owning the HI/LO pair.
// Multiplies run for MULT_LAT busy cycles. Divides use a radix-2 restoring
// divider and run for 34 busy cycles: setup, 32 iterations, sign fix.
// A divide by zero takes one busy cycle and leaves Lo=all ones, Hi=A.
// Optional feature macro: MND_MADD_EN enables the MADD/MADDU accumulate ops
// (Op 100/101). Without it, Op 1xx is reserved and ignored.
module mnd_sequencer #(
  parameter int MULT_LAT = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLo_WE,
  input  logic        HiLo_Sel,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DSETUP,
    S_DITER,
    S_DFIX
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;

  logic [31:0] a_reg, b_reg;
  logic        signed_reg;
  logic        dz_reg;
`ifdef MND_MADD_EN
  logic        acc_reg;
`endif

  logic [31:0] quo_reg, rem_reg, dvs_reg;
  logic        q_neg_reg, r_neg_reg;

  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        op_is_mul, op_is_div, start_accept;
  logic        mul_finish;
  logic [63:0] prod_u, prod_s, prod, mul_result;
  logic [32:0] trial, diff;

  // Decode which ops start a sequence; everything else is reserved.
  always_comb begin
    op_is_mul = (Op == 3'b000) || (Op == 3'b001);
`ifdef MND_MADD_EN
    op_is_mul = op_is_mul || (Op == 3'b100) || (Op == 3'b101);
`endif
    op_is_div    = (Op[2:1] == 2'b01);
    start_accept = (state_reg == S_IDLE) && Start && (op_is_mul || op_is_div);
    mul_finish   = (state_reg == S_MUL) && (cnt_reg == 5'd0);
  end

  // Multiplier result: full 64-bit product, optionally accumulated into HI:LO.
  always_comb begin
    prod_u = {32'b0, a_reg} * {32'b0, b_reg};
    prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    prod   = signed_reg ? prod_s : prod_u;
`ifdef MND_MADD_EN
    mul_result = acc_reg ? ({hi_reg, lo_reg} + prod) : prod;
`else
    mul_result = prod;
`endif
  end

  // One restoring shift-subtract step: bring in the next dividend bit.
  always_comb begin
    trial = {rem_reg, quo_reg[31]};
    diff  = trial - {1'b0, dvs_reg};
  end

  // State and counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_accept) begin
          if (op_is_mul) begin
            state_next = S_MUL;
            cnt_next   = 5'(MULT_LAT - 1);
          end else if (B == 32'd0) begin
            state_next = S_DFIX;
          end else begin
            state_next = S_DSETUP;
          end
        end
      end
      S_MUL: begin
        if (cnt_reg == 5'd0) state_next = S_IDLE;
        else                 cnt_next   = cnt_reg - 5'd1;
      end
      S_DSETUP: begin
        state_next = S_DITER;
        cnt_next   = 5'd31;
      end
      S_DITER: begin
        if (cnt_reg == 5'd0) state_next = S_DFIX;
        else                 cnt_next   = cnt_reg - 5'd1;
      end
      S_DFIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture and divider datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      signed_reg <= 1'b0;
      dz_reg     <= 1'b0;
`ifdef MND_MADD_EN
      acc_reg    <= 1'b0;
`endif
      quo_reg    <= 32'd0;
      rem_reg    <= 32'd0;
      dvs_reg    <= 32'd0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_accept) begin
            a_reg      <= A;
            b_reg      <= B;
            signed_reg <= Op[0];
            dz_reg     <= (B == 32'd0);
`ifdef MND_MADD_EN
            acc_reg    <= Op[2];
`endif
          end
        end
        S_DSETUP: begin
          quo_reg   <= (signed_reg && a_reg[31]) ? (~a_reg + 32'd1) : a_reg;
          dvs_reg   <= (signed_reg && b_reg[31]) ? (~b_reg + 32'd1) : b_reg;
          rem_reg   <= 32'd0;
          q_neg_reg <= signed_reg && (a_reg[31] ^ b_reg[31]);
          r_neg_reg <= signed_reg && a_reg[31];
        end
        S_DITER: begin
          if (!diff[32]) begin
            rem_reg <= diff[31:0];
            quo_reg <= {quo_reg[30:0], 1'b1};
          end else begin
            rem_reg <= trial[31:0];
            quo_reg <= {quo_reg[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO update: results on the final edge, mthi/mtlo only while idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (mul_finish) begin
      hi_reg <= mul_result[63:32];
      lo_reg <= mul_result[31:0];
    end else if (state_reg == S_DFIX) begin
      if (dz_reg) begin
        lo_reg <= 32'hFFFF_FFFF;
        hi_reg <= a_reg;
      end else begin
        lo_reg <= q_neg_reg ? (~quo_reg + 32'd1) : quo_reg;
        hi_reg <= r_neg_reg ? (~rem_reg + 32'd1) : rem_reg;
      end
    end else if ((state_reg == S_IDLE) && HiLo_WE && !start_accept) begin
      if (HiLo_Sel) hi_reg <= WData;
      else          lo_reg <= WData;
    end
  end

  // Done pulses in the cycle after the result edge.
  always_ff @(posedge Clk) begin
    if (Reset) done_reg <= 1'b0;
    else       done_reg <= mul_finish || (state_reg == S_DFIX);
  end

  assign Busy = (state_reg != S_IDLE);
  assign Done = done_reg;
  assign Hi   = hi_reg;
  assign Lo   = lo_reg;

endmodule

// File: tb/tb_mnd_sequencer.sv
// tb_mnd_sequencer: directed and randomized checks of mnd_sequencer against
// an arithmetic reference model of HI/LO and operation latency.
module tb_mnd_sequencer;

  localparam int MLAT = 5;

  logic        Clk = 1'b0;
  logic        Reset, Start, HiLo_WE, HiLo_Sel;
  logic [2:0]  Op;
  logic [31:0] A, B, WData;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  mnd_sequencer #(.MULT_LAT(MLAT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiLo_WE(HiLo_WE), .HiLo_Sel(HiLo_Sel), .WData(WData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics in plain 64-bit arithmetic; returns busy length.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    logic [63:0] p;
    longint sa, sb, q, r;
    bit mul_ok;
    mul_ok = (op == 3'd0) || (op == 3'd1);
`ifdef MND_MADD_EN
    mul_ok = mul_ok || (op == 3'd4) || (op == 3'd5);
`endif
    if (mul_ok) begin
      if (op[0]) p = longint'($signed(a)) * longint'($signed(b));
      else       p = {32'b0, a} * {32'b0, b};
      if (op[2]) p = p + {m_hi, m_lo};
      m_hi = p[63:32];
      m_lo = p[31:0];
      lat = MLAT;
    end else if (op[2:1] == 2'b01) begin
      if (b == 32'd0) begin
        m_lo = 32'hFFFF_FFFF;
        m_hi = a;
        lat = 1;
      end else begin
        if (op[0]) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
        end else begin
          sa = longint'({32'b0, a});
          sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
        lat = 34;
      end
    end else begin
      lat = 0;
    end
  endtask

  // Issue one op, watch Busy/Done, compare HI/LO. poke_at>0 injects a Start
  // plus mthi during that busy cycle; wr_same adds a write alongside Start.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input bit wr_same);
    int lat, busy_n, dones;
    bit fin;
    model(op, a, b, lat);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    if (wr_same) begin
      HiLo_WE = 1'b1; HiLo_Sel = 1'($urandom); WData = $urandom;
    end
    @(negedge Clk);
    Start = 1'b0; HiLo_WE = 1'b0;
    A = $urandom; B = $urandom; Op = 3'($urandom);
    busy_n = 0; dones = 0; fin = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      if (Busy) begin
        busy_n++;
        if (Done) dones++;
        if (busy_n == poke_at) begin
          Start = 1'b1; Op = 3'b000; A = 32'd2; B = 32'd3;
          HiLo_WE = 1'b1; HiLo_Sel = 1'b1; WData = 32'hDEAD;
        end else begin
          Start = 1'b0; HiLo_WE = 1'b0;
        end
        @(negedge Clk);
      end else begin
        fin = 1;
      end
    end
    Start = 1'b0; HiLo_WE = 1'b0;
    if (!fin) check("timeout", 64'd1, 64'd0);
    check("busy_len", 64'(busy_n), 64'(lat));
    check("done_busy", 64'(dones), 64'd0);
    check("done", {63'd0, Done}, {63'd0, (lat > 0)});
    check("hi", {32'd0, Hi}, {32'd0, m_hi});
    check("lo", {32'd0, Lo}, {32'd0, m_lo});
    $display("txn op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", op, a, b, busy_n, Hi, Lo);
    @(negedge Clk);
    check("done_drop", {63'd0, Done}, 64'd0);
    check("hilo_hold", {Hi, Lo}, {m_hi, m_lo});
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] data);
    @(negedge Clk);
    HiLo_WE = 1'b1; HiLo_Sel = sel; WData = data;
    @(negedge Clk);
    HiLo_WE = 1'b0;
    if (sel) m_hi = data;
    else     m_lo = data;
    check("mt_hi", {32'd0, Hi}, {32'd0, m_hi});
    check("mt_lo", {32'd0, Lo}, {32'd0, m_lo});
    $display("txn mt%s data=%h hi=%h lo=%h", sel ? "hi" : "lo", data, Hi, Lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    Reset = 1'b1; Start = 1'b0; HiLo_WE = 1'b0; HiLo_Sel = 1'b0;
    Op = 3'd0; A = 32'd0; B = 32'd0; WData = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_hilo", {Hi, Lo}, 64'd0);

    // Multiply sign handling.
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(3'b000, 32'hFFFF_FFFF, 32'd2, 0, 0);
    // Divides, divide by zero, signed overflow.
    run_op(3'b010, 32'd100, 32'd7, 0, 0);
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'b011, 32'd5, 32'd0, 0, 0);
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    // Busy interlock: Start and mthi during the divide are ignored.
    run_op(3'b010, 32'd10, 32'd3, 5, 0);
    check("lock_lo", {32'd0, Lo}, 64'd3);
    check("lock_hi", {32'd0, Hi}, 64'd1);
    // mtlo/mthi while idle.
    write_reg(1'b0, 32'h1234);
    write_reg(1'b1, 32'h5678);
    // Write in the same cycle as an accepted Start is dropped.
    run_op(3'b000, 32'd6, 32'd7, 0, 1);

    // Reset in the middle of a divide.
    @(negedge Clk);
    Start = 1'b1; Op = 3'b010; A = 32'd1000; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    repeat (21) @(negedge Clk);
    check("mid_busy", {63'd0, Busy}, 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_hilo", {Hi, Lo}, 64'd0);
    check("abort_done", {63'd0, Done}, 64'd0);
    @(negedge Clk);
    check("abort_done2", {63'd0, Done}, 64'd0);
    $display("txn reset_mid_divide hi=%h lo=%h", Hi, Lo);
    run_op(3'b000, 32'd3, 32'd4, 0, 0);

    // Accumulate multiply (or reserved op when the feature is absent).
    write_reg(1'b1, 32'd0);
    write_reg(1'b0, 32'hFFFF_FFFF);
    run_op(3'b100, 32'd1, 32'd1, 0, 0);
    // Reserved ops.
    run_op(3'b110, 32'd9, 32'd9, 0, 0);
    run_op(3'b111, 32'd9, 32'd9, 0, 0);

    // Randomized mix of ops and idle writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        write_reg(1'($urandom), $urandom);
      else
        run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
